mixed_opcode_decoder: RTL and testbench

MIXED_OPCODE_DECODER -- requirements
Module: mixed_opcode_decoder

---
 rtl/mixed_opcode_decoder.sv | 151 +++++++++++++++
 tb/tb_mixed_opcode_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mixed_opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mixed_opcode_decoder
// Description : Decodes 9-bit opcode tags into type/tag/error and queues the
//               results in a DEPTH-entry FIFO. Optional per-type statistics
//               counters are enabled with MIXED_OPCODE_DECODER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mixed_opcode_decoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_valid,
    output logic             enc_ready,
    input  logic [8:0]       enc_data,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [2:0]       dec_type,
    output logic [8:0]       dec_tag,
    output logic             dec_err,
    output logic             err_sticky,
`ifdef MIXED_OPCODE_DECODER_STATS_EN
    input  logic [2:0]       stat_sel,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_cnt,
`endif
    input  logic             err_clr
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_NUM_TYPES = 5;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = 1;
    localparam logic [c_PTR_W:0]   c_CNT_ONE   = 1;
    localparam logic [c_PTR_W:0]   c_FULL      = (c_PTR_W+1)'(DEPTH);
    localparam logic [8:0]         c_VALUE [c_NUM_TYPES] = '{9'h000, 9'h040, 9'h080, 9'h0c0, 9'h100};
    localparam logic [8:0]         c_MASK  [c_NUM_TYPES] = '{9'h1c0, 9'h1c0, 9'h1c0, 9'h1c0, 9'h1fe};

    logic [2:0]         w_type;
    logic [8:0]         w_tag;
    logic               w_err;
    logic               w_push;
    logic               w_pop;
    logic [c_PTR_W:0]   w_count_nxt;
    logic [12:0]        w_head;

    logic [12:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_enc_ready;
    logic               r_err_sticky;

    // Scan from the highest index down so the lowest matching type wins.
    always_comb begin
        w_type = 3'd7;
        w_tag  = enc_data;
        w_err  = 1'b1;
        for (int t = c_NUM_TYPES - 1; t >= 0; t--) begin
            if ((enc_data & c_MASK[t]) == c_VALUE[t]) begin
                w_type = 3'(t);
                w_tag  = enc_data & ~c_MASK[t];
                w_err  = 1'b0;
            end
        end
    end

    assign w_push = enc_valid && r_enc_ready;
    assign w_pop  = (r_count != '0) && dec_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Ready is registered from the next count so dec_ready never reaches enc_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_enc_ready  <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_enc_ready <= (w_count_nxt != c_FULL);
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            if (w_push && w_err) begin
                r_err_sticky <= 1'b1;
            end else if (err_clr) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_type, w_tag, w_err};
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign dec_valid  = (r_count != '0);
    assign enc_ready  = r_enc_ready;
    assign err_sticky = r_err_sticky;
    assign dec_type   = dec_valid ? w_head[12:10] : 3'd0;
    assign dec_tag    = dec_valid ? w_head[9:1]   : 9'd0;
    assign dec_err    = dec_valid ? w_head[0]     : 1'b0;

`ifdef MIXED_OPCODE_DECODER_STATS_EN
    localparam int               c_NUM_STATS = 6;
    localparam logic [CNT_W-1:0] c_STAT_ONE  = 1;

    logic [CNT_W-1:0] r_stat [c_NUM_STATS];
    logic [2:0]       w_stat_idx;

    assign w_stat_idx = w_err ? 3'd5 : w_type;

    // Clear takes priority over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NUM_STATS; i++) begin
            if (rst || stat_clr) begin
                r_stat[i] <= '0;
            end else if (w_push && (w_stat_idx == 3'(i)) && (r_stat[i] != '1)) begin
                r_stat[i] <= r_stat[i] + c_STAT_ONE;
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < c_NUM_STATS; i++) begin
            if (stat_sel == 3'(i)) begin
                stat_cnt = r_stat[i];
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mixed_opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mixed_opcode_decoder
// Description : Directed self-checking bench for mixed_opcode_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mixed_opcode_decoder;

`ifdef MIXED_OPCODE_DECODER_STATS_EN
    localparam int c_CNT_W = 4;
`else
    localparam int c_CNT_W = 16;
`endif

    logic             clk;
    logic             rst;
    logic             enc_valid;
    logic             enc_ready;
    logic [8:0]       enc_data;
    logic             dec_valid;
    logic             dec_ready;
    logic [2:0]       dec_type;
    logic [8:0]       dec_tag;
    logic             dec_err;
    logic             err_sticky;
    logic             err_clr;
    logic [2:0]       stat_sel;
    logic             stat_clr;
    logic [c_CNT_W-1:0] stat_cnt;

    int n_pass;
    int n_total;

`ifdef MIXED_OPCODE_DECODER_STATS_EN
    mixed_opcode_decoder #(.DEPTH(2), .CNT_W(c_CNT_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enc_valid  (enc_valid),
        .enc_ready  (enc_ready),
        .enc_data   (enc_data),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_type   (dec_type),
        .dec_tag    (dec_tag),
        .dec_err    (dec_err),
        .err_sticky (err_sticky),
        .stat_sel   (stat_sel),
        .stat_clr   (stat_clr),
        .stat_cnt   (stat_cnt),
        .err_clr    (err_clr)
    );
`else
    mixed_opcode_decoder #(.DEPTH(2), .CNT_W(c_CNT_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enc_valid  (enc_valid),
        .enc_ready  (enc_ready),
        .enc_data   (enc_data),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_type   (dec_type),
        .dec_tag    (dec_tag),
        .dec_err    (dec_err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );
    assign stat_cnt = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single edge; the decoded result is visible on return.
    task automatic send(input logic [8:0] data);
        enc_data  = data;
        enc_valid = 1'b1;
        step();
        enc_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [2:0] t, input logic [8:0] g, input logic e);
        check({tag, "_valid"}, 32'(dec_valid), 32'd1);
        check({tag, "_type"},  32'(dec_type),  32'(t));
        check({tag, "_tag"},   32'(dec_tag),   32'(g));
        check({tag, "_err"},   32'(dec_err),   32'(e));
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        enc_valid = 1'b0;
        enc_data  = 9'h000;
        dec_ready = 1'b1;
        err_clr   = 1'b0;
        stat_sel  = 3'd0;
        stat_clr  = 1'b0;

        step();
        step();
        check("rst_dec_valid",  32'(dec_valid),  32'd0);
        check("rst_enc_ready",  32'(enc_ready),  32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        check("rst_dec_type",   32'(dec_type),   32'd0);
        check("rst_dec_tag",    32'(dec_tag),    32'd0);
        check("rst_dec_err",    32'(dec_err),    32'd0);
        check("rst_stat_cnt",   32'(stat_cnt),   32'd0);

        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(enc_ready), 32'd1);

        // Basic decode of each class, including the type-4 and illegal boundaries.
        send(9'h045);
        check_out("w045", 3'd1, 9'h005, 1'b0);
        step();
        check("w045_popped", 32'(dec_valid), 32'd0);

        send(9'h101);
        check_out("w101", 3'd4, 9'h001, 1'b0);
        step();
        send(9'h100);
        check_out("w100", 3'd4, 9'h000, 1'b0);
        step();
        check("sticky_clean", 32'(err_sticky), 32'd0);
        send(9'h1c3);
        check_out("w1c3", 3'd7, 9'h1c3, 1'b1);
        check("sticky_set", 32'(err_sticky), 32'd1);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("sticky_clr", 32'(err_sticky), 32'd0);

        err_clr = 1'b1;
        send(9'h102);
        err_clr = 1'b0;
        check_out("w102", 3'd7, 9'h102, 1'b1);
        check("sticky_set_wins", 32'(err_sticky), 32'd1);
        step();

        // Backpressure: fill, stall, try a push while full, then drain in order.
        dec_ready = 1'b0;
        send(9'h000);
        send(9'h0ff);
        check("full_ready", 32'(enc_ready), 32'd0);
        check_out("bp_first", 3'd0, 9'h000, 1'b0);
        send(9'h055);
        check_out("bp_hold", 3'd0, 9'h000, 1'b0);
        check("full_ready_hold", 32'(enc_ready), 32'd0);
        dec_ready = 1'b1;
        step();
        check_out("bp_second", 3'd3, 9'h03f, 1'b0);
        check("ready_after_pop", 32'(enc_ready), 32'd1);
        step();
        check("bp_drained", 32'(dec_valid), 32'd0);

        // Streaming: one word per cycle through the wrapping pointers.
        for (int i = 0; i < 10; i++) begin
            enc_data  = 9'(i);
            enc_valid = 1'b1;
            step();
            check($sformatf("stream%0d_valid", i), 32'(dec_valid), 32'd1);
            check($sformatf("stream%0d_tag", i),   32'(dec_tag),   32'(i));
            check($sformatf("stream%0d_ready", i), 32'(enc_ready), 32'd1);
        end
        enc_valid = 1'b0;
        step();
        check("stream_drained", 32'(dec_valid), 32'd0);

        // Reset with two entries queued discards them.
        dec_ready = 1'b0;
        send(9'h011);
        send(9'h022);
        check("preflush_valid", 32'(dec_valid), 32'd1);
        rst = 1'b1;
        step();
        check("flush_valid", 32'(dec_valid), 32'd0);
        check("flush_ready", 32'(enc_ready), 32'd0);
        rst       = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("flush_idle%0d", i), 32'(dec_valid), 32'd0);
        end

`ifdef MIXED_OPCODE_DECODER_STATS_EN
        // Saturation and clear priority with a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            enc_data  = 9'h080 | 9'(i);
            enc_valid = 1'b1;
            step();
        end
        enc_valid = 1'b0;
        stat_sel  = 3'd2;
        #1;
        check("stat_sat", 32'(stat_cnt), 32'hF);
        stat_sel = 3'd0;
        #1;
        check("stat_type0", 32'(stat_cnt), 32'd0);
        stat_sel = 3'd5;
        #1;
        check("stat_illegal", 32'(stat_cnt), 32'd0);
        stat_sel = 3'd6;
        #1;
        check("stat_sel6", 32'(stat_cnt), 32'd0);
        step();
        stat_clr = 1'b1;
        send(9'h085);
        stat_clr = 1'b0;
        stat_sel = 3'd2;
        #1;
        check("stat_clr_wins", 32'(stat_cnt), 32'd0);
        check_out("stat_word", 3'd2, 9'h005, 1'b0);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
